// File: rtl/tile_assembler.sv
// tile_assembler: reassembles four 3x3 denoise blocks into one 6x6 tile and
// buffers whole tiles in a small FIFO behind a valid/ready output.
//
// Ports:
//   clk, rst_n              clock (rising edge) and asynchronous active-low reset
//   blk_valid / blk_ready   input handshake; one tile is accepted per handshake
//   block_in_0..3           3x3 quadrants (TL, TR, BL, BR), element (0,0) in MSBs
//   valid / out_ready       output handshake; one tile is taken per handshake
//   pixel_out               6x6 tile in raster order, pixel (0,0) in MSBs
//   overflow                sticky flag: blk_valid seen while blk_ready was low
//   tile_cnt                tiles popped since reset (present only when the
//                           TILE_ASSEMBLER_TILE_CNT_EN macro is defined)
module tile_assembler #(
    parameter int BIT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    blk_valid,
    output logic                    blk_ready,
    input  logic [9*BIT_WIDTH-1:0]  block_in_0,
    input  logic [9*BIT_WIDTH-1:0]  block_in_1,
    input  logic [9*BIT_WIDTH-1:0]  block_in_2,
    input  logic [9*BIT_WIDTH-1:0]  block_in_3,
    output logic                    valid,
    input  logic                    out_ready,
    output logic [36*BIT_WIDTH-1:0] pixel_out,
`ifdef TILE_ASSEMBLER_TILE_CNT_EN
    output logic [15:0]             tile_cnt,
`endif
    output logic                    overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 36*BIT_WIDTH;
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    logic [TW-1:0] tile;
    logic [TW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    // Quadrant k lands at row offset 3*(k/2), column offset 3*(k%2); the
    // offsets are folded into the constant bit positions below.
    always_comb begin
        tile = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                tile[(36-6*i-j)*BIT_WIDTH-1 -: BIT_WIDTH] = block_in_0[(9-3*i-j)*BIT_WIDTH-1 -: BIT_WIDTH];
                tile[(33-6*i-j)*BIT_WIDTH-1 -: BIT_WIDTH] = block_in_1[(9-3*i-j)*BIT_WIDTH-1 -: BIT_WIDTH];
                tile[(18-6*i-j)*BIT_WIDTH-1 -: BIT_WIDTH] = block_in_2[(9-3*i-j)*BIT_WIDTH-1 -: BIT_WIDTH];
                tile[(15-6*i-j)*BIT_WIDTH-1 -: BIT_WIDTH] = block_in_3[(9-3*i-j)*BIT_WIDTH-1 -: BIT_WIDTH];
            end
        end
    end

    // Ready depends only on the registered count, so a full FIFO never
    // accepts in the same cycle as a pop.
    assign blk_ready = (count_q != FULL);
    assign valid     = (count_q != '0);
    assign pixel_out = mem_q[rd_ptr_q];
    assign overflow  = overflow_q;
    assign push      = blk_valid && blk_ready;
    assign pop       = valid && out_ready;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = (push && !pop) ? count_q + 1'b1 :
                     (pop && !push) ? count_q - 1'b1 : count_q;
        overflow_d = overflow_q || (blk_valid && !blk_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) mem_q[wr_ptr_q] <= tile;
        end
    end

`ifdef TILE_ASSEMBLER_TILE_CNT_EN
    logic [15:0] tile_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tile_cnt_q <= '0;
        else if (pop) tile_cnt_q <= tile_cnt_q + 16'd1;
    end

    assign tile_cnt = tile_cnt_q;
`endif
endmodule

// File: tb/tb_tile_assembler.sv
// tb_tile_assembler: table-driven and scoreboard checks for tile_assembler.
module tb_tile_assembler;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          blk_valid, blk_ready, valid, out_ready, overflow;
    logic [71:0]   bi0, bi1, bi2, bi3;
    logic [287:0]  pixel_out;
`ifdef TILE_ASSEMBLER_TILE_CNT_EN
    logic [15:0]   tile_cnt;
`endif

    int checks = 0;
    int fails  = 0;
    logic [287:0] sb[$];

    typedef struct {
        logic [71:0] b0, b1, b2, b3;
        logic [47:0] row0, row3, row5;
    } vec_t;
    vec_t vt[3];

    always #5 clk = ~clk;

    tile_assembler #(.BIT_WIDTH(BW), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .blk_valid(blk_valid), .blk_ready(blk_ready),
        .block_in_0(bi0), .block_in_1(bi1), .block_in_2(bi2), .block_in_3(bi3),
        .valid(valid), .out_ready(out_ready), .pixel_out(pixel_out),
`ifdef TILE_ASSEMBLER_TILE_CNT_EN
        .tile_cnt(tile_cnt),
`endif
        .overflow(overflow)
    );

    // Reference model: pixel (r,c) comes from quadrant (r/3)*2+c/3,
    // element (r%3, c%3).
    function automatic logic [287:0] model(input logic [71:0] a0, a1, a2, a3);
        logic [71:0]  q[4];
        logic [287:0] t;
        int k, e;
        q[0] = a0; q[1] = a1; q[2] = a2; q[3] = a3;
        t = '0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                k = (r/3)*2 + c/3;
                e = (r%3)*3 + c%3;
                t[(35-(r*6+c))*8 +: 8] = q[k][(8-e)*8 +: 8];
            end
        end
        return t;
    endfunction

    task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkv(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand();
        bi0 = 72'({$urandom(), $urandom(), $urandom()});
        bi1 = 72'({$urandom(), $urandom(), $urandom()});
        bi2 = 72'({$urandom(), $urandom(), $urandom()});
        bi3 = 72'({$urandom(), $urandom(), $urandom()});
    endtask

    // Handshakes are evaluated half a cycle before the edge that performs them;
    // inputs change only just after rising edges, so they are stable here.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL sb_unexpected: got tile %h expected none", pixel_out);
                end else begin
                    chk("sb_tile", pixel_out, sb.pop_front());
                end
            end
            if (blk_valid && blk_ready) sb.push_back(model(bi0, bi1, bi2, bi3));
        end
    end

    logic [287:0] ta, tb, td, tf;

    initial begin
        vt[0] = '{72'h000102030405060708, 72'h000102030405060708,
                  72'h000102030405060708, 72'h000102030405060708,
                  48'h000102000102, 48'h000102000102, 48'h060708060708};
        vt[1] = '{{9{8'h10}}, {9{8'h20}}, {9{8'h30}}, {9{8'h40}},
                  48'h101010202020, 48'h303030404040, 48'h303030404040};
        vt[2] = '{72'h000102030405060708, 72'h101112131415161718,
                  72'h202122232425262728, 72'h303132333435363738,
                  48'h000102101112, 48'h202122303132, 48'h262728363738};

        rst_n = 1'b0; blk_valid = 1'b0; out_ready = 1'b0;
        bi0 = '0; bi1 = '0; bi2 = '0; bi3 = '0;
        #3;
        chkv("rst_valid", int'(valid), 0);
        chk("rst_pixel", pixel_out, '0);
        chkv("rst_overflow", int'(overflow), 0);
        chkv("rst_blk_ready", int'(blk_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single tiles: visible exactly one cycle after acceptance.
        for (int i = 0; i < 3; i++) begin
            cyc();
            bi0 = vt[i].b0; bi1 = vt[i].b1; bi2 = vt[i].b2; bi3 = vt[i].b3;
            blk_valid = 1'b1; out_ready = 1'b1;
            cyc();
            blk_valid = 1'b0;
            chkv("vec_valid", int'(valid), 1);
            chk("vec_row0", 288'(pixel_out[287 -: 48]), 288'(vt[i].row0));
            chk("vec_row3", 288'(pixel_out[143 -: 48]), 288'(vt[i].row3));
            chk("vec_row5", 288'(pixel_out[47 -: 48]), 288'(vt[i].row5));
            cyc();
            chkv("vec_valid_drop", int'(valid), 0);
        end

        // Streaming: one tile in and one out every cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_rand();
            blk_valid = 1'b1;
            cyc();
            chkv("stream_blk_ready", int'(blk_ready), 1);
            chkv("stream_valid", int'(valid), 1);
        end
        blk_valid = 1'b0;
        cyc();
        cyc();
        chkv("stream_drained_valid", int'(valid), 0);
        chkv("stream_sb_empty", sb.size(), 0);
        chkv("stream_overflow", int'(overflow), 0);

        // Back-pressure: fill, overflow attempt, drain with a push after the first pop.
        out_ready = 1'b0;
        set_rand(); ta = model(bi0, bi1, bi2, bi3); blk_valid = 1'b1;
        cyc();
        chkv("bp_ready_after_a", int'(blk_ready), 1);
        set_rand(); tb = model(bi0, bi1, bi2, bi3);
        cyc();
        chkv("bp_full_ready", int'(blk_ready), 0);
        chk("bp_head_a", pixel_out, ta);
        set_rand();
        cyc();
        blk_valid = 1'b0;
        chkv("bp_overflow", int'(overflow), 1);
        chk("bp_hold_a", pixel_out, ta);
        cyc();
        chk("bp_hold_a2", pixel_out, ta);
        chkv("bp_hold_valid", int'(valid), 1);
        out_ready = 1'b1;
        #1;
        chkv("bp_no_passthru", int'(blk_ready), 0);
        cyc();
        chkv("bp_ready_resume", int'(blk_ready), 1);
        chk("bp_head_b", pixel_out, tb);
        set_rand(); td = model(bi0, bi1, bi2, bi3); blk_valid = 1'b1;
        cyc();
        blk_valid = 1'b0;
        chk("bp_head_d", pixel_out, td);
        cyc();
        chkv("bp_drained_valid", int'(valid), 0);
        chkv("bp_sb_empty", sb.size(), 0);
        chkv("bp_overflow_sticky", int'(overflow), 1);

        // Asynchronous reset with one tile buffered.
        out_ready = 1'b0;
        set_rand(); blk_valid = 1'b1;
        cyc();
        blk_valid = 1'b0;
        chkv("ar_valid_before", int'(valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chkv("ar_valid", int'(valid), 0);
        chk("ar_pixel", pixel_out, '0);
        chkv("ar_blk_ready", int'(blk_ready), 1);
        chkv("ar_overflow", int'(overflow), 0);
        sb.delete();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        set_rand(); tf = model(bi0, bi1, bi2, bi3);
        blk_valid = 1'b1; out_ready = 1'b1;
        cyc();
        blk_valid = 1'b0;
        chkv("ar_new_valid", int'(valid), 1);
        chk("ar_new_tile", pixel_out, tf);
        cyc();
        chkv("ar_new_drop", int'(valid), 0);

`ifdef TILE_ASSEMBLER_TILE_CNT_EN
        #2;
        rst_n = 1'b0;
        #1;
        chkv("cnt_reset", int'(tile_cnt), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_rand(); blk_valid = 1'b1;
            cyc();
        end
        blk_valid = 1'b0;
        cyc();
        cyc();
        chkv("cnt_three", int'(tile_cnt), 3);
        force dut.tile_cnt_q = 16'hFFFF;
        cyc();
        release dut.tile_cnt_q;
        set_rand(); blk_valid = 1'b1;
        cyc();
        blk_valid = 1'b0;
        cyc();
        chkv("cnt_wrap", int'(tile_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
